// File: rtl/i2c_master_byte_ctrl_pkg.sv
// i2c_pkg: shared definitions for the I2C master byte-level sequencer.
//   - command op-codes presented on cmd_op
//   - ACK/NACK bit values
//   - FSM state encoding and a helper that identifies states driving a go
package i2c_pkg;

    localparam logic [2:0] CMD_START = 3'd0;
    localparam logic [2:0] CMD_STOP  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_ISSUE_START = 4'd1,
        ST_ISSUE_STOP  = 4'd2,
        ST_WR_BIT      = 4'd3,
        ST_WR_ACK      = 4'd4,
        ST_RD_BIT      = 4'd5,
        ST_RD_ACK      = 4'd6,
        ST_GAP         = 4'd7,
        ST_DONE        = 4'd8
    } state_e;

    // States in which exactly one primitive go is (or is about to be) high.
    function automatic logic is_issue(input state_e s);
        return (s == ST_ISSUE_START) || (s == ST_ISSUE_STOP) ||
               (s == ST_WR_BIT)      || (s == ST_WR_ACK)     ||
               (s == ST_RD_BIT)      || (s == ST_RD_ACK);
    endfunction

endpackage

// File: rtl/i2c_master_byte_ctrl_go_handshake.sv
// i2c_go_handshake: single go/finish handshake engine with watchdog.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   launch_i        raise go at the next edge (only honoured while go is low)
//   finish_i        finish of the currently selected primitive
//   go_o            go level, to be muxed to the selected primitive
//   done_o          finish accepted this cycle (go drops next cycle)
//   timeout_o       watchdog expired this cycle (go drops next cycle)
module i2c_go_handshake #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic launch_i,
    input  logic finish_i,
    output logic go_o,
    output logic done_o,
    output logic timeout_o
);

    localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic        WD_EN = (TIMEOUT != 0);
    // Counter value seen in the TIMEOUT-th cycle of go high.
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic          go_q, go_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign go_o      = go_q;
    assign done_o    = go_q && finish_i;
    // A finish in the expiry cycle takes priority over the watchdog.
    assign timeout_o = WD_EN && go_q && !finish_i && (cnt_q == LAST);

    always_comb begin
        go_d  = go_q;
        cnt_d = cnt_q;
        if (go_q) begin
            if (done_o || timeout_o) begin
                go_d  = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (launch_i) begin
            go_d  = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            go_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            go_q  <= go_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: byte-level sequencer over the I2C bit primitives.
// Accepts START / STOP / WRITE byte / READ byte commands one at a time and
// drives the start, stop, write-bit and read-bit primitives in order.
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/cmd_wdata/cmd_nack op-code, WRITE byte, READ ACK-slot value
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata/rsp_ack/rsp_err READ byte, WRITE ACK bit, error; held between pulses
//   busy                      FSM not in IDLE
//   *_go/*_finish             primitive handshakes; wbit_data/rbit_data bit values
module i2c_master_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       busy,
    output logic       start_go,
    input  logic       start_finish,
    output logic       stop_go,
    input  logic       stop_finish,
    output logic       wbit_go,
    input  logic       wbit_finish,
    output logic       wbit_data,
    output logic       rbit_go,
    input  logic       rbit_finish,
    input  logic       rbit_data
);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] wdata_q, wdata_d;
    logic       nack_q, nack_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       ack_phase_q, ack_phase_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       wbit_data_q, wbit_data_d;

    logic       launch, hs_go, hs_done, hs_timeout, sel_finish;

    // Only the primitive owned by the current state can complete the handshake.
    always_comb begin
        sel_finish = 1'b0;
        case (state_q)
            ST_ISSUE_START:       sel_finish = start_finish;
            ST_ISSUE_STOP:        sel_finish = stop_finish;
            ST_WR_BIT, ST_RD_ACK: sel_finish = wbit_finish;
            ST_WR_ACK, ST_RD_BIT: sel_finish = rbit_finish;
            default:              sel_finish = 1'b0;
        endcase
    end

    // go is raised on the edge that enters an issue state; issue states are
    // only entered from IDLE or GAP, so one low cycle separates gos in a byte.
    assign launch = is_issue(state_d) && !is_issue(state_q);

    i2c_go_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
        .clock     (clock),
        .reset_n   (reset_n),
        .launch_i  (launch),
        .finish_i  (sel_finish),
        .go_o      (hs_go),
        .done_o    (hs_done),
        .timeout_o (hs_timeout)
    );

    assign start_go  = hs_go && (state_q == ST_ISSUE_START);
    assign stop_go   = hs_go && (state_q == ST_ISSUE_STOP);
    assign wbit_go   = hs_go && ((state_q == ST_WR_BIT) || (state_q == ST_RD_ACK));
    assign rbit_go   = hs_go && ((state_q == ST_WR_ACK) || (state_q == ST_RD_BIT));
    assign wbit_data = wbit_data_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_ack   = ack_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        nack_d      = nack_q;
        bit_idx_d   = bit_idx_q;
        ack_phase_d = ack_phase_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        ack_d       = ack_q;
        err_d       = err_q;
        wbit_data_d = wbit_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    wdata_d     = cmd_wdata;
                    nack_d      = cmd_nack;
                    bit_idx_d   = 3'd7;
                    ack_phase_d = 1'b0;
                    shift_d     = '0;
                    case (cmd_op)
                        CMD_START: state_d = ST_ISSUE_START;
                        CMD_STOP:  state_d = ST_ISSUE_STOP;
                        CMD_WRITE: begin
                            state_d     = ST_WR_BIT;
                            wbit_data_d = cmd_wdata[7];
                        end
                        CMD_READ:  state_d = ST_RD_BIT;
                        default: begin
                            state_d = ST_DONE;
                            rdata_d = '0;
                            ack_d   = NACK;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_ISSUE_START, ST_ISSUE_STOP: begin
                if (hs_done) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                    ack_d   = NACK;
                    err_d   = 1'b0;
                end
            end
            ST_WR_BIT, ST_RD_BIT: begin
                if (hs_done) begin
                    // Wrap from 0 marks the end of the byte phase.
                    bit_idx_d   = bit_idx_q - 3'd1;
                    ack_phase_d = (bit_idx_q == 3'd0);
                    state_d     = ST_GAP;
                    if (state_q == ST_RD_BIT) begin
                        shift_d = {shift_q[6:0], rbit_data};
                    end
                end
            end
            ST_GAP: begin
                if (op_q == CMD_WRITE) begin
                    if (ack_phase_q) begin
                        state_d = ST_WR_ACK;
                    end else begin
                        state_d     = ST_WR_BIT;
                        wbit_data_d = wdata_q[bit_idx_q];
                    end
                end else begin
                    if (ack_phase_q) begin
                        state_d     = ST_RD_ACK;
                        wbit_data_d = nack_q;
                    end else begin
                        state_d = ST_RD_BIT;
                    end
                end
            end
            ST_WR_ACK: begin
                if (hs_done) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                    ack_d   = rbit_data;
                    err_d   = 1'b0;
                end
            end
            ST_RD_ACK: begin
                if (hs_done) begin
                    state_d = ST_DONE;
                    rdata_d = shift_q;
                    ack_d   = NACK;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                wbit_data_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Watchdog expiry abandons the rest of the command.
        if (hs_timeout) begin
            state_d     = ST_DONE;
            rdata_d     = '0;
            ack_d       = NACK;
            err_d       = 1'b1;
            wbit_data_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rdata_q     <= '0;
            ack_q       <= NACK;
            err_q       <= 1'b0;
            wbit_data_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            wbit_data_q <= wbit_data_d;
        end
    end

    // Command context is always loaded before use, so it needs no reset.
    always_ff @(posedge clock) begin
        op_q        <= op_d;
        wdata_q     <= wdata_d;
        nack_q      <= nack_d;
        bit_idx_q   <= bit_idx_d;
        ack_phase_q <= ack_phase_d;
        shift_q     <= shift_d;
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// tb_i2c_master_byte_ctrl: directed bench for i2c_master_byte_ctrl with
// behavioural primitive stubs and a negedge monitor.
module tb_i2c_master_byte_ctrl;

    localparam int DLY = 6;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack;
    logic       rsp_err;
    logic       busy;
    logic       start_go, stop_go, wbit_go, rbit_go, wbit_data;
    logic       start_finish = 1'b0, stop_finish = 1'b0;
    logic       wbit_finish = 1'b0, rbit_finish = 1'b0, rbit_data = 1'b0;

    always #5 clock = ~clock;

    i2c_master_byte_ctrl #(.TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
        .rsp_err(rsp_err), .busy(busy),
        .start_go(start_go), .start_finish(start_finish),
        .stop_go(stop_go), .stop_finish(stop_finish),
        .wbit_go(wbit_go), .wbit_finish(wbit_finish), .wbit_data(wbit_data),
        .rbit_go(rbit_go), .rbit_finish(rbit_finish), .rbit_data(rbit_data)
    );

    // Stub configuration (written only by the stimulus process)
    logic [15:0] rd_pat = 16'h0;
    int          rbase = 0;
    int          hang_at = -1;

    // Monitor / stub state (written only by the negedge process)
    int          cyc = 0, rv_n = 0, st_n = 0, sp_n = 0, wr_n = 0, rr_n = 0;
    int          multi_n = 0, late_n = 0, unst_n = 0, rfin_n = 0;
    int          low_run = 1000, min_gap = 1000, hi_run = 0, last_hi = 0;
    int          acc_cyc = 0, rv_cyc = 0;
    int          sc = 0, pc = 0, wc = 0, rc = 0;
    logic [15:0] wlog = '0;
    logic [7:0]  plog = '0;
    logic        sg_p = 0, pg_p = 0, wg_p = 0, rg_p = 0, wd_p = 1, any_p = 0;
    logic        sf_p = 0, pf_p = 0, wf_p = 0, rf_p = 0;

    always @(negedge clock) begin
        int  ng;
        int  idx;
        logic any;
        cyc++;
        ng  = int'(start_go) + int'(stop_go) + int'(wbit_go) + int'(rbit_go);
        any = (ng != 0);
        if (ng > 1) multi_n++;
        if (start_go && !sg_p) begin st_n++; plog = {plog[5:0], 2'd0}; end
        if (stop_go  && !pg_p) begin sp_n++; plog = {plog[5:0], 2'd1}; end
        if (wbit_go  && !wg_p) begin wr_n++; plog = {plog[5:0], 2'd2}; wlog = {wlog[14:0], wbit_data}; end
        if (rbit_go  && !rg_p) begin rr_n++; plog = {plog[5:0], 2'd3}; end
        if (wbit_go && wg_p && (wbit_data != wd_p)) unst_n++;
        if ((sf_p && start_go) || (pf_p && stop_go) || (wf_p && wbit_go) || (rf_p && rbit_go)) late_n++;
        if (any) begin
            if (!any_p && low_run < min_gap) min_gap = low_run;
            hi_run++;
        end else begin
            if (any_p) begin last_hi = hi_run; hi_run = 0; low_run = 1; end
            else low_run++;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rsp_valid) begin rv_n++; rv_cyc = cyc; end
        // Primitive stubs: finish after DLY cycles of go high
        if (start_go) begin sc++; start_finish = (sc == DLY); end
        else begin sc = 0; start_finish = 1'b0; end
        if (stop_go) begin pc++; stop_finish = (pc == DLY); end
        else begin pc = 0; stop_finish = 1'b0; end
        if (wbit_go) begin wc++; wbit_finish = (wc == DLY) && (wr_n != hang_at); end
        else begin wc = 0; wbit_finish = 1'b0; end
        if (rbit_go) begin
            rc++;
            rbit_finish = (rc == DLY);
            if (rbit_finish) begin
                idx = rfin_n - rbase;
                rbit_data = (idx >= 0 && idx < 16) ? rd_pat[15-idx] : 1'b0;
                rfin_n++;
            end
        end else begin
            rc = 0; rbit_finish = 1'b0;
        end
        sg_p = start_go; pg_p = stop_go; wg_p = wbit_go; rg_p = rbit_go;
        wd_p = wbit_data; any_p = any;
        sf_p = start_finish; pf_p = stop_finish; wf_p = wbit_finish; rf_p = rbit_finish;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] wd, input logic nk);
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin @(posedge clock); #1; n++; end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; cmd_nack = nk;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int base, input int limit, input string tag);
        int n;
        n = 0;
        while (rv_n == base && n < limit) begin @(posedge clock); #1; n++; end
        repeat (3) @(posedge clock);
        #1;
        chk(tag, 32'(rv_n - base), 32'd1);
    endtask

    int b_rv, b_st, b_sp, b_wr, b_rr;

    task automatic snap();
        b_rv = rv_n; b_st = st_n; b_sp = sp_n; b_wr = wr_n; b_rr = rr_n;
        rbase = rfin_n;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_wdata = '0; cmd_nack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_rsp_ack", 32'(rsp_ack), 32'd1);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_wbit_data", 32'(wbit_data), 32'd1);
        chk("rst_gos", 32'({start_go, stop_go, wbit_go, rbit_go}), 32'd0);

        // WRITE 0xA5, ACK returned as 0
        snap(); rd_pat = 16'h0000;
        send(3'd2, 8'hA5, 1'b0);
        wait_rsp(b_rv, 300, "wr_rsp_pulses");
        chk("wr_bits", 32'(wlog[7:0]), 32'hA5);
        chk("wr_wbit_gos", 32'(wr_n - b_wr), 32'd8);
        chk("wr_rbit_gos", 32'(rr_n - b_rr), 32'd1);
        chk("wr_ack", 32'(rsp_ack), 32'd0);
        chk("wr_err", 32'(rsp_err), 32'd0);

        // READ with NACK, stub returns 0x3C
        snap(); rd_pat = 16'h3C00;
        send(3'd3, 8'h00, 1'b1);
        wait_rsp(b_rv, 300, "rd_rsp_pulses");
        chk("rd_rdata", 32'(rsp_rdata), 32'h3C);
        chk("rd_rbit_gos", 32'(rr_n - b_rr), 32'd8);
        chk("rd_wbit_gos", 32'(wr_n - b_wr), 32'd1);
        chk("rd_nack_bit", 32'(wlog[0]), 32'd1);
        chk("rd_err", 32'(rsp_err), 32'd0);

        // Watchdog: 4th write bit never finishes
        snap(); rd_pat = 16'h0000; hang_at = wr_n + 4;
        send(3'd2, 8'hFF, 1'b0);
        wait_rsp(b_rv, 300, "to_rsp_pulses");
        chk("to_go_len", 32'(last_hi), 32'd16);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_rdata", 32'(rsp_rdata), 32'h0);
        chk("to_ack", 32'(rsp_ack), 32'd1);
        chk("to_idle", 32'({cmd_ready, busy}), 32'b10);
        repeat (10) @(posedge clock);
        #1;
        chk("to_wbit_gos", 32'(wr_n - b_wr), 32'd4);
        chk("to_rbit_gos", 32'(rr_n - b_rr), 32'd0);
        hang_at = -1;

        // START then STOP back to back
        snap();
        send(3'd0, 8'h00, 1'b0);
        send(3'd1, 8'h00, 1'b0);
        n = 0;
        while (rv_n - b_rv < 2 && n < 100) begin @(posedge clock); #1; n++; end
        repeat (3) @(posedge clock);
        #1;
        chk("ss_rsp_pulses", 32'(rv_n - b_rv), 32'd2);
        chk("ss_start_gos", 32'(st_n - b_st), 32'd1);
        chk("ss_stop_gos", 32'(sp_n - b_sp), 32'd1);
        chk("ss_order", 32'(plog[3:0]), 32'b0001);
        chk("ss_err", 32'(rsp_err), 32'd0);

        // Reserved op 5
        snap();
        send(3'd5, 8'h00, 1'b0);
        wait_rsp(b_rv, 20, "rsv_rsp_pulses");
        chk("rsv_latency", 32'(rv_cyc - acc_cyc), 32'd1);
        chk("rsv_err", 32'(rsp_err), 32'd1);
        chk("rsv_no_go", 32'((st_n - b_st) + (sp_n - b_sp) + (wr_n - b_wr) + (rr_n - b_rr)), 32'd0);

        // Reset in the middle of a READ, then a normal WRITE
        snap(); rd_pat = 16'hFFFF;
        send(3'd3, 8'h00, 1'b0);
        n = 0;
        while (!(rr_n - b_rr >= 3 && rbit_go) && n < 300) begin @(posedge clock); #1; n++; end
        chk("rr_reached_bit", 32'(rbit_go), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rr_gos_async", 32'({start_go, stop_go, wbit_go, rbit_go}), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rr_no_rsp", 32'(rv_n - b_rv), 32'd0);
        chk("rr_ready", 32'({cmd_ready, busy}), 32'b10);
        snap(); rd_pat = 16'h8000;
        send(3'd2, 8'h5A, 1'b0);
        wait_rsp(b_rv, 300, "rr_wr_rsp_pulses");
        chk("rr_wr_bits", 32'(wlog[7:0]), 32'h5A);
        chk("rr_wr_ack", 32'(rsp_ack), 32'd1);
        chk("rr_wr_err", 32'(rsp_err), 32'd0);

        // Properties over the whole run
        chk("one_go_at_a_time", 32'(multi_n), 32'd0);
        chk("go_drops_after_finish", 32'(late_n), 32'd0);
        chk("wbit_data_stable", 32'(unst_n), 32'd0);
        chk("gap_at_least_one", 32'(min_gap >= 1), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
